// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: fixed-priority ALU writeback merged with a
// FIFO-buffered long-latency result stream, plus a pending-write scoreboard.
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        AluWrite,
    input  logic [4:0]  AluReg,
    input  logic [31:0] AluData,
    input  logic        LongValid,
    input  logic [4:0]  LongReg,
    input  logic [31:0] LongData,
    output logic        LongReady,
    input  logic        IssueValid,
    input  logic [4:0]  IssueReg,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic        Busy1,
    output logic        Busy2,
    output logic        DrainReq,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       reg_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [STV_W-1:0] starve_reg, starve_next;
    logic [31:0]      pending_reg, pending_next;
    logic             reg_write_reg, reg_write_next;
    logic [4:0]       write_register_reg, write_register_next;
    logic [31:0]      write_data_reg, write_data_next;

    logic        alu_hit, fifo_empty, push, pop, clear_valid, set_valid;
    logic [4:0]  head_reg;
    logic [31:0] head_data;

    assign alu_hit    = AluWrite && (AluReg != 5'd0);
    assign fifo_empty = (count_reg == '0);
    // Readiness depends only on the registered count: a pop never frees a slot
    // for a push on the same edge.
    assign LongReady  = !reset && (count_reg < CNT_W'(DEPTH));
    assign push       = LongValid && LongReady;
    assign pop        = !alu_hit && !fifo_empty;
    assign head_reg   = reg_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];
    assign clear_valid = pop && (head_reg != 5'd0);
    assign set_valid   = IssueValid && (IssueReg != 5'd0);

    assign Busy1         = pending_reg[ReadRegister1];
    assign Busy2         = pending_reg[ReadRegister2];
    assign DrainReq      = (starve_reg == STV_W'(STARVE_LIMIT));
    assign RegWrite      = reg_write_reg;
    assign WriteRegister = write_register_reg;
    assign WriteData     = write_data_reg;

    // Scoreboard bits: set beats clear on the same edge; bit 0 never pends.
    assign pending_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pending
            assign pending_next[gi] = (set_valid && (IssueReg == 5'(gi))) ||
                                      (pending_reg[gi] && !(clear_valid && (head_reg == 5'(gi))));
        end
    endgenerate

    always_comb begin
        wr_ptr_next         = wr_ptr_reg;
        rd_ptr_next         = rd_ptr_reg;
        count_next          = count_reg;
        starve_next         = starve_reg;
        reg_write_next      = 1'b0;
        write_register_next = 5'd0;
        write_data_next     = 32'd0;

        if (push)
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        if (pop)
            rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;

        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (fifo_empty || pop)
            starve_next = '0;
        else if (starve_reg < STV_W'(STARVE_LIMIT))
            starve_next = starve_reg + 1'b1;

        if (alu_hit) begin
            reg_write_next      = 1'b1;
            write_register_next = AluReg;
            write_data_next     = AluData;
        end else if (pop) begin
            // A long result aimed at r0 is consumed without a write.
            reg_write_next      = (head_reg != 5'd0);
            write_register_next = head_reg;
            write_data_next     = head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr_reg]  <= LongReg;
            data_mem[wr_ptr_reg] <= LongData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            starve_reg         <= '0;
            pending_reg        <= '0;
            reg_write_reg      <= 1'b0;
            write_register_reg <= 5'd0;
            write_data_reg     <= 32'd0;
        end else begin
            wr_ptr_reg         <= wr_ptr_next;
            rd_ptr_reg         <= rd_ptr_next;
            count_reg          <= count_next;
            starve_reg         <= starve_next;
            pending_reg        <= pending_next;
            reg_write_reg      <= reg_write_next;
            write_register_reg <= write_register_next;
            write_data_reg     <= write_data_next;
        end
    end
endmodule
